// File: rtl/mult_arbiter_pkg.sv
// mult_arbiter_pkg: shared types and constants for the multiplier arbiter.
//   arb_state_t : arbiter FSM encoding
//   op_pair_t   : registered operand pair driven to the multiplier
//   id_width()  : tag width for a given requester count (never below 1)
package mult_arbiter_pkg;

  localparam int OP_W   = 32;
  localparam int PROD_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } arb_state_t;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } op_pair_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// mult_arbiter_if: request, response and multiplier-side signals of mult_arbiter.
//   req_*  : per-requester valid/ready handshake with packed operand lanes
//   rsp_*  : single response channel, product tagged with requester index
//   mult_* : start/busy protocol towards the shared mult32x32
// Modports: slave = the arbiter, master = clients plus multiplier.
interface mult_arbiter_if
  import mult_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_width(N_REQ)
);

  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ-1:0]           req_ready;
  logic [N_REQ-1:0][OP_W-1:0] req_a;
  logic [N_REQ-1:0][OP_W-1:0] req_b;

  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [ID_W-1:0]            rsp_id;
  logic [PROD_W-1:0]          rsp_product;

  logic                       mult_start;
  logic [OP_W-1:0]            mult_a;
  logic [OP_W-1:0]            mult_b;
  logic                       mult_busy;
  logic [PROD_W-1:0]          mult_product;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mult_busy, mult_product,
    output req_ready, rsp_valid, rsp_id, rsp_product, mult_start, mult_a, mult_b
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, mult_busy, mult_product,
    input  req_ready, rsp_valid, rsp_id, rsp_product, mult_start, mult_a, mult_b
  );

endinterface

// File: rtl/mult_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick.
//   req    : request vector
//   ptr    : highest-priority index this cycle
//   enable : when low, nothing is granted
//   grant  : one-hot grant, idx : its index, any : a grant was made
// The pointer register lives in the parent.
module rr_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             enable,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  // Walk the requesters starting at ptr and wrapping; first hit wins.
  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (enable && !any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one iterative mult32x32 among N_REQ requesters.
//   clk, reset : clock and asynchronous active-low reset
//   bus        : mult_arbiter_if slave port (requests, response, multiplier)
// One transaction at a time: grant in IDLE, pulse start, wait for busy to
// rise and fall, capture the product with its tag, hold it until accepted.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic           clk,
  input  logic           reset,
  mult_arbiter_if.slave  bus
);

  arb_state_t        state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   tag;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W-1:0]   nxt_ptr;
  logic [N_REQ-1:0]  gnt;
  logic              gnt_any;
  logic              arb_en;
  op_pair_t          ops;
  logic              start_q;
  logic              rsp_valid_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [PROD_W-1:0] rsp_prod_q;

  // Reset gates the grant so req_ready reads 0 while reset is held, even
  // though the state register already sits in IDLE.
  assign arb_en = (state == IDLE) && reset;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
    .req    (bus.req_valid),
    .ptr    (rr_ptr),
    .enable (arb_en),
    .grant  (gnt),
    .idx    (gnt_idx),
    .any    (gnt_any)
  );

  assign nxt_ptr = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      tag         <= '0;
      ops         <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_prod_q  <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_any) begin
          ops.a   <= bus.req_a[gnt_idx];
          ops.b   <= bus.req_b[gnt_idx];
          tag     <= gnt_idx;
          rr_ptr  <= nxt_ptr;
          start_q <= 1'b1;
          state   <= ISSUE;
        end
        ISSUE: begin
          start_q <= 1'b0;
          state   <= WAIT_BUSY;
        end
        WAIT_BUSY: if (bus.mult_busy) state <= WAIT_DONE;
        // Product is valid in the cycle busy is seen low.
        WAIT_DONE: if (!bus.mult_busy) begin
          rsp_prod_q  <= bus.mult_product;
          rsp_id_q    <= tag;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = gnt;
  assign bus.mult_start  = start_q;
  assign bus.mult_a      = ops.a;
  assign bus.mult_b      = ops.b;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_product = rsp_prod_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: self-checking bench for mult_arbiter with a behavioural
// iterative multiplier (programmable busy length) and a response scoreboard.
module tb_mult_arbiter;
  import mult_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mult_arbiter_if #(.N_REQ(N), .ID_W(IW)) bus ();

  mult_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Multiplier model: busy for mlat cycles after start; product shows a
  // junk value while busy and the real result from the cycle busy falls.
  int          mlat = 3;
  int          mcnt;
  logic [63:0] mres;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.mult_busy    <= 1'b0;
      bus.mult_product <= '0;
      mcnt             <= 0;
      mres             <= '0;
    end else if (bus.mult_start) begin
      bus.mult_busy    <= 1'b1;
      mcnt             <= mlat - 1;
      mres             <= 64'(bus.mult_a) * 64'(bus.mult_b);
      bus.mult_product <= 64'hBADB_AD00_BADB_AD00;
    end else if (bus.mult_busy) begin
      if (mcnt == 0) begin
        bus.mult_busy    <= 1'b0;
        bus.mult_product <= mres;
      end else begin
        mcnt <= mcnt - 1;
      end
    end
  end

  typedef struct {
    logic [IW-1:0] id;
    logic [63:0]   prod;
  } exp_t;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [63:0] exp;
  } vec_t;

  exp_t          sb[$];
  int            grant_log[$];
  vec_t          vecs[7];
  int            checks = 0, errors = 0;
  int            cyc = 0, nstart = 0, rsp_cyc = 0, nrsp = 0;
  int            acc_cyc = 0, first_rsp_cyc = 0;
  logic [IW-1:0] last_id;
  logic [63:0]   last_prod;
  logic [N-1:0]  acc;
  bit            hold = 1'b0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample at negedge (scoreboard push/pop, invariants), then
  // return just after the next posedge with accepted requests withdrawn.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    acc = bus.req_valid & bus.req_ready;
    if (bus.req_ready != '0)
      chk($onehot(bus.req_ready) && (acc == bus.req_ready), "grant_onehot", 64'(bus.req_ready), 64'(acc));
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        sb.push_back('{IW'(i), 64'(bus.req_a[i]) * 64'(bus.req_b[i])});
        grant_log.push_back(i);
        acc_cyc = cyc;
      end
    end
    if (bus.mult_start) nstart++;
    if (bus.rsp_valid) begin
      rsp_cyc++;
      if (rsp_cyc == 1) first_rsp_cyc = cyc;
      chk(bus.req_ready == '0, "no_grant_in_resp", 64'(bus.req_ready), 64'd0);
      if (bus.rsp_ready) begin
        if (sb.size() == 0) begin
          chk(1'b0, "sb_underflow", 64'(bus.rsp_id), 64'd0);
        end else begin
          e = sb.pop_front();
          chk(bus.rsp_id == e.id, "sb_id", 64'(bus.rsp_id), 64'(e.id));
          chk(bus.rsp_product == e.prod, "sb_product", bus.rsp_product, e.prod);
        end
        last_id   = bus.rsp_id;
        last_prod = bus.rsp_product;
        nrsp++;
      end
    end
    @(posedge clk);
    #1;
    if (!hold) bus.req_valid = bus.req_valid & ~acc;
  endtask

  task automatic wait_rsp(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (nrsp < target && n < budget) begin
      tick();
      n++;
    end
    if (nrsp < target) chk(1'b0, name, 64'(nrsp), 64'(target));
  endtask

  task automatic run_one(input vec_t v);
    int s0, n0;
    mlat          = v.lat;
    rsp_cyc       = 0;
    s0            = nstart;
    n0            = nrsp;
    bus.rsp_ready = 1'b1;
    bus.req_a[v.id]     = v.a;
    bus.req_b[v.id]     = v.b;
    bus.req_valid[v.id] = 1'b1;
    wait_rsp(n0 + 1, 400, "vec_timeout");
    chk(last_id == IW'(v.id), "vec_id", 64'(last_id), 64'(v.id));
    chk(last_prod == v.exp, "vec_product", last_prod, v.exp);
    chk(nstart - s0 == 1, "vec_one_start", 64'(nstart - s0), 64'd1);
    chk(rsp_cyc == 1, "vec_rsp_one_cycle", 64'(rsp_cyc), 64'd1);
    chk(first_rsp_cyc - acc_cyc == v.lat + 3, "vec_latency", 64'(first_rsp_cyc - acc_cyc), 64'(v.lat + 3));
  endtask

  initial begin
    int          n0, s0, n;
    bit          stable, no_rsp, no_gnt;
    logic [IW-1:0]  hid;
    logic [63:0]    hprod;
    logic [31:0]    ma, mb;

    vecs[0] = '{2, 32'h0000_0003, 32'h0000_0005, 2, 64'h0000_0000_0000_000F};
    vecs[1] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{1, 32'h0001_0000, 32'h0001_0000, 1, 64'h0000_0001_0000_0000};
    vecs[3] = '{3, 32'h0000_0000, 32'hDEAD_BEEF, 3, 64'h0000_0000_0000_0000};
    vecs[4] = '{2, 32'h8000_0000, 32'h0000_0002, 5, 64'h0000_0001_0000_0000};
    vecs[5] = '{0, 32'hFFFF_FFFF, 32'h0000_0001, 2, 64'h0000_0000_FFFF_FFFF};
    vecs[6] = '{1, 32'h0000_0007, 32'h0000_0006, 1, 64'h0000_0000_0000_002A};

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    // Reset state, with a request already pending.
    #2 reset = 1'b0;
    bus.req_valid = 4'b0100;
    #1;
    chk(bus.req_ready == '0, "rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk(bus.rsp_valid == 1'b0, "rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk(bus.rsp_id == '0, "rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk(bus.rsp_product == '0, "rst_rsp_product", bus.rsp_product, 64'd0);
    chk(bus.mult_start == 1'b0, "rst_mult_start", 64'(bus.mult_start), 64'd0);
    chk({bus.mult_a, bus.mult_b} == '0, "rst_mult_ops", {bus.mult_a, bus.mult_b}, 64'd0);
    bus.req_valid = '0;
    @(posedge clk);
    #1 reset = 1'b1;

    // Table of single transactions.
    for (int i = 0; i < 7; i++) run_one(vecs[i]);

    // Round-robin with all requesters continuously valid from pointer 0.
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    mlat = 2;
    n0   = nrsp;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i] = 32'(i + 1);
      bus.req_b[i] = 32'h1000 + 32'(i);
    end
    grant_log.delete();
    hold = 1'b1;
    bus.req_valid = '1;
    n = 0;
    while (grant_log.size() < 5 && n < 300) begin
      tick();
      n++;
    end
    bus.req_valid = '0;
    hold = 1'b0;
    chk(grant_log.size() == 5, "rr_grant_count", 64'(grant_log.size()), 64'd5);
    for (int k = 0; k < 5 && k < grant_log.size(); k++)
      chk(grant_log[k] == k % N, "rr_order", 64'(grant_log[k]), 64'(k % N));
    wait_rsp(n0 + 5, 300, "rr_drain_timeout");

    // Backpressure: response held 10 cycles with requester 3 pending.
    mlat          = 3;
    bus.rsp_ready = 1'b0;
    bus.req_a[1]  = 32'h1234;
    bus.req_b[1]  = 32'h10;
    bus.req_valid[1] = 1'b1;
    n = 0;
    while (!bus.rsp_valid && n < 100) begin
      tick();
      n++;
    end
    chk(bus.rsp_valid, "bp_rsp_timeout", 64'(bus.rsp_valid), 64'd1);
    bus.req_a[3] = 32'h3;
    bus.req_b[3] = 32'h3;
    bus.req_valid[3] = 1'b1;
    hid    = bus.rsp_id;
    hprod  = bus.rsp_product;
    s0     = nstart;
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.rsp_id != hid || bus.rsp_product != hprod || !bus.rsp_valid) stable = 1'b0;
    end
    chk(stable, "bp_rsp_stable", bus.rsp_product, hprod);
    chk(hprod == 64'h12340 && hid == 2'd1, "bp_rsp_value", hprod, 64'h12340);
    chk(nstart == s0, "bp_no_start", 64'(nstart - s0), 64'd0);
    n0 = nrsp;
    bus.rsp_ready = 1'b1;
    tick();
    chk(acc == '0, "bp_no_grant_same_cycle", 64'(acc), 64'd0);
    tick();
    chk(acc == 4'b1000, "bp_grant_next_cycle", 64'(acc), 64'h8);
    wait_rsp(n0 + 2, 100, "bp_drain_timeout");

    // Reset in WAIT_DONE: pointer sits at 3 before reset.
    mlat = 20;
    bus.req_a[2] = 32'h55;
    bus.req_b[2] = 32'h66;
    bus.req_valid[2] = 1'b1;
    n = 0;
    while (!bus.mult_busy && n < 20) begin
      tick();
      n++;
    end
    for (int k = 0; k < 3; k++) tick();
    @(negedge clk);
    reset = 1'b0;
    bus.req_a[1] = 32'h0000_0101;
    bus.req_b[1] = 32'h0000_0011;
    bus.req_a[3] = 32'h9;
    bus.req_b[3] = 32'h9;
    bus.req_valid = 4'b1010;
    #1;
    chk(bus.rsp_valid == 1'b0 && bus.req_ready == '0, "mid_rst_valid_ready",
        64'({bus.rsp_valid, bus.req_ready}), 64'd0);
    chk(bus.rsp_id == '0 && bus.rsp_product == '0, "mid_rst_rsp", bus.rsp_product, 64'd0);
    chk(bus.mult_start == 1'b0 && bus.mult_a == '0 && bus.mult_b == '0, "mid_rst_mult",
        {bus.mult_a, bus.mult_b}, 64'd0);
    sb.delete();
    grant_log.delete();
    mlat = 2;
    n0   = nrsp;
    @(posedge clk);
    #1 reset = 1'b1;
    wait_rsp(n0 + 2, 200, "rst_drain_timeout");
    chk(grant_log.size() == 2 && grant_log[0] == 1, "rst_ptr_zero",
        64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'd1);

    // Stalled multiplier: busy for 100 cycles, requester 2 waiting.
    mlat = 100;
    n0   = nrsp;
    bus.req_a[0] = 32'hABCD;
    bus.req_b[0] = 32'h1111;
    bus.req_valid[0] = 1'b1;
    n = 0;
    while (!bus.mult_busy && n < 20) begin
      tick();
      n++;
    end
    ma = bus.mult_a;
    mb = bus.mult_b;
    s0 = nstart;
    bus.req_a[2] = 32'h5;
    bus.req_b[2] = 32'h9;
    bus.req_valid[2] = 1'b1;
    stable = 1'b1;
    no_rsp = 1'b1;
    no_gnt = 1'b1;
    for (int k = 0; k < 95; k++) begin
      tick();
      if (bus.mult_a != ma || bus.mult_b != mb) stable = 1'b0;
      if (bus.rsp_valid) no_rsp = 1'b0;
      if (acc != '0) no_gnt = 1'b0;
    end
    chk(ma == 32'hABCD && mb == 32'h1111, "stall_ops", {ma, mb}, {32'hABCD, 32'h1111});
    chk(stable, "stall_ops_stable", {bus.mult_a, bus.mult_b}, {ma, mb});
    chk(no_rsp && no_gnt, "stall_no_rsp_no_grant", 64'({no_rsp, no_gnt}), 64'd3);
    chk(nstart == s0, "stall_no_extra_start", 64'(nstart - s0), 64'd0);
    mlat = 2;
    wait_rsp(n0 + 2, 200, "stall_drain_timeout");
    chk(sb.size() == 0, "sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
